// File: rtl/amber48_pkg.sv
// amber48_pkg: shared data-path width plus the data-memory arbiter's limits and state type.
package amber48_pkg;

  localparam int XLEN                     = 48;
  localparam int AMBER48_DMEM_ARB_MAX_REQ = 4;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/amber48_dmem_arbiter_if.sv
// amber48_dmem_arbiter_if: requester-side and amber48_dmem-side signals of the data-port arbiter.
interface amber48_dmem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int XLEN = amber48_pkg::XLEN;

  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ-1:0]      we_i;
  logic [NUM_REQ*XLEN-1:0] addr_i;
  logic [NUM_REQ*XLEN-1:0] wdata_i;
  logic [XLEN-1:0]         rdata_o;
  logic [NUM_REQ-1:0]      ready_o;
  logic [NUM_REQ-1:0]      trap_o;
  logic [NUM_REQ-1:0]      grant_o;
  logic                    dmem_req_o;
  logic                    dmem_we_o;
  logic [XLEN-1:0]         dmem_addr_o;
  logic [XLEN-1:0]         dmem_wdata_o;
  logic [XLEN-1:0]         dmem_rdata_i;
  logic                    dmem_ready_i;
  logic                    dmem_trap_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, dmem_rdata_i, dmem_ready_i, dmem_trap_i,
    output rdata_o, ready_o, trap_o, grant_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, dmem_rdata_i, dmem_ready_i, dmem_trap_i,
    input  rdata_o, ready_o, trap_o, grant_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o
  );

endinterface

// File: rtl/amber48_rr_pick.sv
// amber48_rr_pick: combinational round-robin selector; first set request at or after ptr, with wrap.
module amber48_rr_pick #(
  parameter  int N  = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int            sum_s;
  logic [PW-1:0] pos_s;
  logic          hit_s;

  // Walk the requesters starting at ptr; the first hit wins and masks later ones.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum_s = 0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s      = int'(ptr) + i;
      pos_s      = (sum_s >= N) ? PW'(sum_s - N) : PW'(sum_s);
      hit_s      = !valid && req[pos_s];
      gnt[pos_s] = gnt[pos_s] | hit_s;
      idx        = hit_s ? pos_s : idx;
      valid      = valid | hit_s;
    end
  end

endmodule

// File: rtl/amber48_dmem_arbiter.sv
// amber48_dmem_arbiter: round-robin owner of the shared amber48_dmem port (NUM_REQ requesters, 0 = core).
// Define AMBER48_ARB_TIMEOUT_EN to complete a stalled access with a trap after TIMEOUT_CYCLES.
module amber48_dmem_arbiter
  import amber48_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  amber48_dmem_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);

  arb_state_e         state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [PW-1:0]      grant_idx_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               dmem_req_r;
  logic               we_r;
  logic [XLEN-1:0]    addr_r;
  logic [XLEN-1:0]    wdata_r;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [PW-1:0]      pick_idx_s;
  logic               pick_valid_s;
  logic [XLEN-1:0]    addr_s  [NUM_REQ];
  logic [XLEN-1:0]    wdata_s [NUM_REQ];
  logic               busy_s;
  logic               done_s;
  logic               tmo_s;

  amber48_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req_i),
    .ptr   (rr_ptr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Unflatten the per-requester address and write-data buses.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_s[k]  = bus.addr_i[k*XLEN +: XLEN];
      wdata_s[k] = bus.wdata_i[k*XLEN +: XLEN];
    end
  end

  // A completion in the reset cycle is dropped, so rst_i gates both completion sources.
  assign busy_s = (state_r == ARB_BUSY) && !rst_i;
  assign done_s = busy_s && bus.dmem_ready_i;

`ifdef AMBER48_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;
  assign tmo_s = busy_s && !bus.dmem_ready_i && (tmo_cnt_r == TW'(TIMEOUT_CYCLES));
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^TIMEOUT_CYCLES;
  assign tmo_s        = 1'b0;
`endif

  // Ownership FSM: latch the winner in IDLE, hold the access from registers in BUSY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ARB_IDLE;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
      grant_r     <= '0;
      dmem_req_r  <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
`ifdef AMBER48_ARB_TIMEOUT_EN
      tmo_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            state_r     <= ARB_BUSY;
            grant_r     <= pick_gnt_s;
            grant_idx_r <= pick_idx_s;
            dmem_req_r  <= 1'b1;
            we_r        <= bus.we_i[pick_idx_s];
            addr_r      <= addr_s[pick_idx_s];
            wdata_r     <= wdata_s[pick_idx_s];
`ifdef AMBER48_ARB_TIMEOUT_EN
            tmo_cnt_r   <= '0;
`endif
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (done_s || tmo_s) begin
            state_r    <= ARB_IDLE;
            grant_r    <= '0;
            dmem_req_r <= 1'b0;
            rr_ptr_r   <= (grant_idx_r == PW'(NUM_REQ - 1)) ? '0 : grant_idx_r + PW'(1);
          end
`ifdef AMBER48_ARB_TIMEOUT_EN
          else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
`else
          else begin
            state_r <= ARB_BUSY;
          end
`endif
        end
        default: begin
          state_r    <= ARB_IDLE;
          grant_r    <= '0;
          dmem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Completion is steered combinationally to the owner only; everything else reads zero.
  always_comb begin
    bus.ready_o = '0;
    bus.trap_o  = '0;
    bus.rdata_o = '0;
    if (done_s) begin
      bus.ready_o = grant_r;
      bus.trap_o  = bus.dmem_trap_i ? grant_r : '0;
      bus.rdata_o = bus.dmem_rdata_i;
    end else if (tmo_s) begin
      bus.ready_o = grant_r;
      bus.trap_o  = grant_r;
    end else begin
      bus.rdata_o = '0;
    end
  end

  assign bus.grant_o      = grant_r;
  assign bus.dmem_req_o   = dmem_req_r;
  assign bus.dmem_we_o    = we_r;
  assign bus.dmem_addr_o  = addr_r;
  assign bus.dmem_wdata_o = wdata_r;

endmodule

// File: tb/tb_amber48_dmem_arbiter.sv
// tb_amber48_dmem_arbiter: scoreboard bench for the two-requester data-port arbiter.
module tb_amber48_dmem_arbiter;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [47:0] rd;
    logic [1:0]  trp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   dmem_mode = 0;
  int   dmem_lat = 0;
  logic trap_cfg = 1'b0;
  int   wait_cnt = 0;
  int   done_cnt [2];
  exp_t sb_q [$];
  exp_t e;

  amber48_dmem_arbiter_if #(.NUM_REQ(2)) bus ();

  amber48_dmem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [47:0] data_for(input logic [47:0] a);
    return (a == 48'h10) ? 48'h123456789ABC : {a[23:0], ~a[23:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Downstream memory model: mode 0 answers after dmem_lat wait cycles, 1 never answers, 2 is manual.
  always @(posedge clk) begin
    #1;
    if (dmem_mode == 0 && bus.dmem_req_o === 1'b1) begin
      if (wait_cnt == dmem_lat) begin
        bus.dmem_ready_i = 1'b1;
        bus.dmem_rdata_i = data_for(bus.dmem_addr_o);
        bus.dmem_trap_i  = trap_cfg;
        wait_cnt         = 0;
      end else begin
        bus.dmem_ready_i = 1'b0;
        wait_cnt++;
      end
    end else if (dmem_mode != 2) begin
      bus.dmem_ready_i = 1'b0;
      bus.dmem_rdata_i = 48'h0;
      bus.dmem_trap_i  = 1'b0;
      wait_cnt         = 0;
    end
  end

  // Completion monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (bus.ready_o != 2'b00) begin
        if (bus.ready_o[0]) done_cnt[0]++;
        if (bus.ready_o[1]) done_cnt[1]++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 64'(bus.ready_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_ready", 64'(bus.ready_o), 64'(e.rdy));
          chk("sb_rdata", 64'(bus.rdata_o), 64'(e.rd));
          chk("sb_trap",  64'(bus.trap_o),  64'(e.trp));
        end
      end else begin
        chk("quiet_rdata", 64'(bus.rdata_o), 64'd0);
        chk("quiet_trap",  64'(bus.trap_o),  64'd0);
      end
    end
  end

  task automatic push_exp(input bit idx, input logic [47:0] rd, input logic trp);
    exp_t x;
    x.rdy = idx ? 2'b10 : 2'b01;
    x.rd  = rd;
    x.trp = trp ? x.rdy : 2'b00;
    sb_q.push_back(x);
  endtask

  task automatic do_txn(input bit idx, input logic we, input logic [47:0] addr,
                        input logic [47:0] wdata, input logic trp, input int lat);
    int  n;
    int  base;
    bit  seen;
    base = idx ? 48 : 0;
    bus.we_i[idx]             = we;
    bus.addr_i[base +: 48]    = addr;
    bus.wdata_i[base +: 48]   = wdata;
    trap_cfg                  = trp;
    dmem_lat                  = lat;
    push_exp(idx, data_for(addr), trp);
    bus.req_i[idx]            = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      sample();
      if (n == 1) begin
        chk("txn_dmem_req",   64'(bus.dmem_req_o),   64'd1);
        chk("txn_dmem_addr",  64'(bus.dmem_addr_o),  64'(addr));
        chk("txn_dmem_we",    64'(bus.dmem_we_o),    64'(we));
        chk("txn_dmem_wdata", 64'(bus.dmem_wdata_o), 64'(wdata));
      end
      seen = bus.ready_o[idx];
    end
    chk("txn_done", 64'(seen), 64'd1);
    chk("txn_latency", 64'(n), 64'(1 + lat));
    bus.req_i[idx] = 1'b0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] gseq [8];
    int         d0;
    int         d1;
    int         n;
    bit         seen;
    gseq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    bus.req_i        = 2'b11;
    bus.we_i         = 2'b00;
    bus.addr_i       = {48'h200, 48'h100};
    bus.wdata_i      = '0;
    bus.dmem_ready_i = 1'b0;
    bus.dmem_rdata_i = 48'h0;
    bus.dmem_trap_i  = 1'b0;

    // Reset held three cycles with both requesters asking.
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1'b1;
      sample();
      chk("rst_ctrl", 64'({bus.grant_o, bus.ready_o, bus.trap_o, bus.dmem_req_o, bus.dmem_we_o}), 64'd0);
      chk("rst_rdata", 64'(bus.rdata_o), 64'd0);
      chk("rst_addr", 64'(bus.dmem_addr_o), 64'd0);
    end
    rst = 1'b0;
    push_exp(1'b0, data_for(48'h100), 1'b0);
    tick();
    sample();
    chk("rst_first_grant", 64'(bus.grant_o), 64'd1);
    bus.req_i = 2'b00;
    tick();
    sample();
    chk("post_first_grant", 64'(bus.grant_o), 64'd0);

    // Single read from the core port.
    do_txn(1'b0, 1'b0, 48'h10, 48'h0, 1'b0, 0);

    // Write from requester 1 that drops its request while the memory stalls.
    bus.we_i[1] = 1'b1;
    bus.addr_i[95:48] = 48'h20;
    bus.wdata_i[95:48] = 48'hAAAA;
    dmem_lat = 3;
    trap_cfg = 1'b0;
    push_exp(1'b1, data_for(48'h20), 1'b0);
    bus.req_i[1] = 1'b1;
    tick();
    bus.req_i[1] = 1'b0;
    bus.addr_i[95:48] = 48'hDEAD0000;
    bus.wdata_i[95:48] = 48'h5555;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("wr_hold_addr",  64'(bus.dmem_addr_o),  64'h20);
      chk("wr_hold_wdata", 64'(bus.dmem_wdata_o), 64'hAAAA);
      chk("wr_hold_we",    64'(bus.dmem_we_o),    64'd1);
      chk("wr_ready", 64'(bus.ready_o), (k == 3) ? 64'd2 : 64'd0);
      if (k < 3) tick();
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      sample();
      chk("wr_single_pulse", 64'(bus.ready_o), 64'd0);
    end

    // Contention: both requesters held for eight cycles.
    bus.we_i = 2'b00;
    bus.addr_i = {48'h400, 48'h300};
    dmem_lat = 0;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    push_exp(1'b0, data_for(48'h300), 1'b0);
    push_exp(1'b1, data_for(48'h400), 1'b0);
    push_exp(1'b0, data_for(48'h300), 1'b0);
    push_exp(1'b1, data_for(48'h400), 1'b0);
    bus.req_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample();
      chk("rr_grant", 64'(bus.grant_o), 64'(gseq[i]));
    end
    bus.req_i = 2'b00;
    tick();
    sample();
    chk("rr_done0", 64'(done_cnt[0] - d0), 64'd2);
    chk("rr_done1", 64'(done_cnt[1] - d1), 64'd2);

    // Faulting access completes with a trap on the same cycle as ready.
    do_txn(1'b0, 1'b0, 48'h50, 48'h0, 1'b1, 0);
    trap_cfg = 1'b0;

    // Reset while busy: the access is abandoned and a same-cycle ready is dropped.
    dmem_mode = 2;
    bus.dmem_ready_i = 1'b0;
    bus.addr_i[47:0] = 48'h60;
    bus.req_i[0] = 1'b1;
    tick();
    sample();
    chk("rstbusy_req", 64'(bus.dmem_req_o), 64'd1);
    rst = 1'b1;
    bus.req_i = 2'b00;
    bus.dmem_ready_i = 1'b1;
    bus.dmem_rdata_i = 48'hCAFE;
    bus.dmem_trap_i = 1'b1;
    #1;
    chk("rstbusy_ready", 64'(bus.ready_o), 64'd0);
    chk("rstbusy_trap", 64'(bus.trap_o), 64'd0);
    chk("rstbusy_rdata", 64'(bus.rdata_o), 64'd0);
    tick();
    sample();
    chk("rstbusy_after_req", 64'(bus.dmem_req_o), 64'd0);
    chk("rstbusy_after_grant", 64'(bus.grant_o), 64'd0);
    rst = 1'b0;
    bus.dmem_ready_i = 1'b0;
    bus.dmem_rdata_i = 48'h0;
    bus.dmem_trap_i = 1'b0;
    dmem_mode = 1;
    tick();

    // Memory never answers.
    bus.addr_i[47:0] = 48'h70;
`ifdef AMBER48_ARB_TIMEOUT_EN
    push_exp(1'b0, 48'h0, 1'b1);
    bus.req_i[0] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      sample();
      seen = bus.ready_o[0];
    end
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_cycles", 64'(n), 64'd5);
    bus.req_i = 2'b00;
    tick();
    sample();
    chk("tmo_req_drop", 64'(bus.dmem_req_o), 64'd0);
    chk("tmo_grant_drop", 64'(bus.grant_o), 64'd0);
`else
    n = 0;
    seen = 1'b0;
    bus.req_i[0] = 1'b1;
    tick();
    bus.req_i = 2'b00;
    for (int i = 0; i < 50; i++) begin
      tick();
    end
    sample();
    chk("notmo_req_held", 64'(bus.dmem_req_o), 64'd1);
    chk("notmo_grant_held", 64'(bus.grant_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk("notmo_rst_req", 64'(bus.dmem_req_o), 64'd0);
`endif
    tick();
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
